// File: rtl/tx_os_sched_pkg.sv
// Shared symbols, beat-type codes and state encoding for the TX ordered-set scheduler.
package tx_os_sched_pkg;

    localparam logic [7:0] COM     = 8'hBC;
    localparam logic [7:0] SKP_SYM = 8'h1C;
    localparam logic [7:0] IDL_SYM = 8'h7C;

    typedef enum logic [1:0] {
        BT_TS   = 2'd0,
        BT_SKP  = 2'd1,
        BT_EIOS = 2'd2
    } beat_type_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EIOS,
        EI
    } sched_state_t;

    // COM followed by three copies of the set's symbol, remaining symbols zero.
    function automatic logic [127:0] os_beat(input logic [7:0] sym);
        return {COM, sym, sym, sym, 96'h0};
    endfunction

endpackage

// File: rtl/tx_os_sched_if.sv
// Signals between the LTSSM/ts_gen side, the scheduler and the per-lane TX FIFO.
interface tx_os_sched_if;
    logic         tx_en;
    logic         eios_req;
    logic         eios_done;
    logic         ts_valid;
    logic [127:0] ts;
    logic         ts_stall;
    logic         fifo_full;
    logic         fifo_wr;
    logic [127:0] fifo_data;
    logic [1:0]   fifo_type;
    logic         skp_overrun;

    modport master (
        output tx_en, eios_req, ts_valid, ts, fifo_full,
        input  eios_done, ts_stall, fifo_wr, fifo_data, fifo_type, skp_overrun
    );

    modport slave (
        input  tx_en, eios_req, ts_valid, ts, fifo_full,
        output eios_done, ts_stall, fifo_wr, fifo_data, fifo_type, skp_overrun
    );
endinterface

// File: rtl/tx_os_sched_skp_timer.sv
// SKP interval counter with pending flag and sticky overrun indication.
module skp_timer #(
    parameter int unsigned SKP_INTERVAL = 1180
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    input  logic skp_taken,
    output logic skp_pending,
    output logic skp_overrun
);

    logic [15:0] cnt;
    logic        wrap;

    assign wrap = run && (cnt == 16'(SKP_INTERVAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            skp_pending <= 1'b0;
            skp_overrun <= 1'b0;
        end else if (clr) begin
            cnt         <= '0;
            skp_pending <= 1'b0;
        end else if (run) begin
            cnt <= wrap ? '0 : cnt + 16'd1;
            // A wrap with a SKP still queued is flagged, never queued twice.
            if (wrap && skp_pending)
                skp_overrun <= 1'b1;
            if (wrap && !skp_pending)
                skp_pending <= 1'b1;
            else if (skp_taken)
                skp_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/tx_os_sched.sv
// Shares the TX FIFO write port between TS beats, periodic SKP and EIOS sequences.
module tx_os_sched
    import tx_os_sched_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned EIOS_CNT     = 1
) (
    input logic         clk,
    input logic         rst,
    tx_os_sched_if.slave bus
);

    sched_state_t state, state_nx;
    logic         skid_valid, skid_valid_nx;
    logic [127:0] skid_data, skid_data_nx;
    logic [1:0]   eios_sent, eios_sent_nx;
    logic         wr_nx;
    logic [127:0] data_nx;
    logic [1:0]   type_nx;
    logic         run, skp_taken, skp_pending, ts_granted;

    skp_timer #(.SKP_INTERVAL(SKP_INTERVAL)) u_skp_timer (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .clr         (~run),
        .skp_taken   (skp_taken),
        .skp_pending (skp_pending),
        .skp_overrun (bus.skp_overrun)
    );

    assign bus.ts_stall  = bus.fifo_full | skp_pending | skid_valid | (state != RUN);
    assign bus.eios_done = (state == EI);

    always_comb begin
        state_nx      = state;
        skid_valid_nx = skid_valid;
        skid_data_nx  = skid_data;
        eios_sent_nx  = eios_sent;
        wr_nx         = 1'b0;
        data_nx       = bus.fifo_data;
        type_nx       = bus.fifo_type;
        run           = 1'b0;
        skp_taken     = 1'b0;
        ts_granted    = 1'b0;
        unique case (state)
            IDLE: begin
                eios_sent_nx = '0;
                if (bus.tx_en)
                    state_nx = RUN;
            end
            RUN: begin
                // Leaving RUN takes precedence over any grant that cycle.
                if (!bus.tx_en) begin
                    state_nx      = IDLE;
                    skid_valid_nx = 1'b0;
                end else if (bus.eios_req) begin
                    state_nx      = EIOS;
                    skid_valid_nx = 1'b0;
                    eios_sent_nx  = '0;
                end else begin
                    run = 1'b1;
                    if (!bus.fifo_full) begin
                        if (skp_pending) begin
                            wr_nx     = 1'b1;
                            data_nx   = os_beat(SKP_SYM);
                            type_nx   = BT_SKP;
                            skp_taken = 1'b1;
                        end else if (skid_valid) begin
                            wr_nx         = 1'b1;
                            data_nx       = skid_data;
                            type_nx       = BT_TS;
                            skid_valid_nx = 1'b0;
                        end else if (bus.ts_valid) begin
                            wr_nx      = 1'b1;
                            data_nx    = bus.ts;
                            type_nx    = BT_TS;
                            ts_granted = 1'b1;
                        end
                    end
                    if (bus.ts_valid && !ts_granted && !skid_valid) begin
                        skid_valid_nx = 1'b1;
                        skid_data_nx  = bus.ts;
                    end
                end
            end
            EIOS: begin
                if (!bus.fifo_full) begin
                    wr_nx        = 1'b1;
                    data_nx      = os_beat(IDL_SYM);
                    type_nx      = BT_EIOS;
                    eios_sent_nx = eios_sent + 2'd1;
                    if (eios_sent == 2'(EIOS_CNT - 1))
                        state_nx = EI;
                end
            end
            EI: begin
                if (!bus.tx_en)
                    state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            eios_sent     <= '0;
            bus.fifo_wr   <= 1'b0;
            bus.fifo_data <= '0;
            bus.fifo_type <= '0;
        end else begin
            state         <= state_nx;
            skid_valid    <= skid_valid_nx;
            skid_data     <= skid_data_nx;
            eios_sent     <= eios_sent_nx;
            bus.fifo_wr   <= wr_nx;
            bus.fifo_data <= data_nx;
            bus.fifo_type <= type_nx;
        end
    end

endmodule

// File: tb/tb_tx_os_sched.sv
// Bench for tx_os_sched: vector table, corner-case sequences and randomized run against a queue model.
module tb_tx_os_sched;

    localparam int unsigned A_IV   = 8;
    localparam int unsigned A_EIOS = 2;
    localparam logic [127:0] SKP_BEAT  = {8'hBC, 8'h1C, 8'h1C, 8'h1C, 96'h0};
    localparam logic [127:0] EIOS_BEAT = {8'hBC, 8'h7C, 8'h7C, 8'h7C, 96'h0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_os_sched_if ifa();
    tx_os_sched_if ifb();

    tx_os_sched #(.SKP_INTERVAL(A_IV), .EIOS_CNT(A_EIOS)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    tx_os_sched #(.SKP_INTERVAL(4), .EIOS_CNT(1)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int   checks = 0;
    int   errors = 0;
    logic stall_s;

    typedef struct {
        logic         tx_en, eios_req, ts_valid, fifo_full;
        logic [127:0] ts;
        logic         exp_stall, exp_wr;
        logic [1:0]   exp_type;
        logic [127:0] exp_data;
    } vec_t;
    vec_t vecs[15];

    typedef enum {M_OFF, M_ON, M_EIOS, M_DONE} mmode_t;
    mmode_t       m_mode;
    logic         m_pending, m_over, m_wr;
    logic [127:0] m_data;
    logic [1:0]   m_type;
    logic [127:0] m_skid[$];
    int unsigned  m_run, m_left;

    // ts_gen never sends while the skid is full; a violation would corrupt the stream.
    always @(negedge clk)
        assert (!(ifa.ts_valid && u_a.skid_valid && !rst))
            else $error("protocol: ts_valid with skid occupied");

    function automatic logic [127:0] tsv(input int n);
        return {8'h2D, 8'h4A, 104'h0, 8'(n)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc_a(input logic tx, input logic eq, input logic tv, input logic ff, input logic [127:0] d);
        ifa.tx_en = tx; ifa.eios_req = eq; ifa.ts_valid = tv; ifa.fifo_full = ff; ifa.ts = d;
        @(negedge clk); stall_s = ifa.ts_stall;
        @(posedge clk); #1;
    endtask

    task automatic cyc_b(input logic tx, input logic ff);
        ifb.tx_en = tx; ifb.eios_req = 1'b0; ifb.ts_valid = 1'b0; ifb.fifo_full = ff; ifb.ts = '0;
        @(negedge clk); stall_s = ifb.ts_stall;
        @(posedge clk); #1;
    endtask

    task automatic m_reset();
        m_mode = M_OFF; m_pending = 0; m_over = 0; m_wr = 0; m_data = '0; m_type = '0;
        m_skid.delete(); m_run = 0; m_left = 0;
    endtask

    task automatic m_emit(input logic [127:0] d, input logic [1:0] t);
        m_wr = 1; m_data = d; m_type = t;
    endtask

    // One clock of the scheduling rules, applied to the inputs held during that cycle.
    task automatic m_step(input logic tx, input logic eq, input logic tv, input logic ff, input logic [127:0] d);
        logic had_skid, old_pend, wrap, took_ts;
        m_wr = 0;
        case (m_mode)
            M_OFF: if (tx) begin m_mode = M_ON; m_run = 0; end
            M_ON: begin
                if (!tx || eq) begin
                    m_pending = 0; m_skid.delete();
                    m_mode = !tx ? M_OFF : M_EIOS;
                    m_left = A_EIOS;
                end else begin
                    had_skid = (m_skid.size() != 0);
                    old_pend = m_pending;
                    wrap = ((m_run % A_IV) == A_IV - 1);
                    m_run++;
                    took_ts = 0;
                    if (!ff) begin
                        if (old_pend) begin m_emit(SKP_BEAT, 2'd1); m_pending = 0; end
                        else if (had_skid) m_emit(m_skid.pop_front(), 2'd0);
                        else if (tv) begin m_emit(d, 2'd0); took_ts = 1; end
                    end
                    if (tv && !took_ts && !had_skid) m_skid.push_back(d);
                    if (wrap) begin
                        if (old_pend) m_over = 1;
                        else m_pending = 1;
                    end
                end
            end
            M_EIOS: if (!ff) begin
                m_emit(EIOS_BEAT, 2'd2);
                m_left--;
                if (m_left == 0) m_mode = M_DONE;
            end
            M_DONE: if (!tx) m_mode = M_OFF;
        endcase
    endtask

    initial begin
        logic prev_stall, last_skp, r_rst, phase0, tx, eq, tv, ff, exp_stall;
        logic [127:0] d;

        ifa.tx_en = 0; ifa.eios_req = 0; ifa.ts_valid = 0; ifa.fifo_full = 0; ifa.ts = '0;
        ifb.tx_en = 0; ifb.eios_req = 0; ifb.ts_valid = 0; ifb.fifo_full = 0; ifb.ts = '0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        chk("reset_wr", ifa.fifo_wr, 0);
        chk("reset_data", ifa.fifo_data, 0);
        chk("reset_type", ifa.fifo_type, 0);
        chk("reset_eios_done", ifa.eios_done, 0);
        chk("reset_overrun", ifa.skp_overrun, 0);
        chk("reset_stall", ifa.ts_stall, 1);

        // SKP_INTERVAL=8 from reset: TS latency, 1-cycle full into skid, first SKP wrap.
        vecs[0]  = '{0, 0, 0, 0, '0,      1, 0, 2'd0, '0};
        vecs[1]  = '{1, 0, 0, 0, '0,      1, 0, 2'd0, '0};
        vecs[2]  = '{1, 0, 1, 0, tsv(1),  0, 1, 2'd0, tsv(1)};
        vecs[3]  = '{1, 0, 1, 0, tsv(2),  0, 1, 2'd0, tsv(2)};
        vecs[4]  = '{1, 0, 1, 1, tsv(3),  1, 0, 2'd0, tsv(2)};
        vecs[5]  = '{1, 0, 0, 0, '0,      1, 1, 2'd0, tsv(3)};
        vecs[6]  = '{1, 0, 0, 0, '0,      0, 0, 2'd0, tsv(3)};
        vecs[7]  = '{1, 0, 1, 0, tsv(4),  0, 1, 2'd0, tsv(4)};
        vecs[8]  = '{1, 0, 1, 0, tsv(5),  0, 1, 2'd0, tsv(5)};
        vecs[9]  = '{1, 0, 1, 0, tsv(6),  0, 1, 2'd0, tsv(6)};
        vecs[10] = '{1, 0, 1, 0, tsv(7),  1, 1, 2'd1, SKP_BEAT};
        vecs[11] = '{1, 0, 0, 0, '0,      1, 1, 2'd0, tsv(7)};
        vecs[12] = '{1, 0, 0, 0, '0,      0, 0, 2'd0, tsv(7)};
        vecs[13] = '{0, 0, 0, 0, '0,      0, 0, 2'd0, tsv(7)};
        vecs[14] = '{0, 0, 0, 0, '0,      1, 0, 2'd0, tsv(7)};
        for (int i = 0; i < 15; i++) begin
            cyc_a(vecs[i].tx_en, vecs[i].eios_req, vecs[i].ts_valid, vecs[i].fifo_full, vecs[i].ts);
            chk($sformatf("vec%0d_stall", i), stall_s, vecs[i].exp_stall);
            chk($sformatf("vec%0d_wr", i), ifa.fifo_wr, vecs[i].exp_wr);
            chk($sformatf("vec%0d_type", i), ifa.fifo_type, vecs[i].exp_type);
            chk($sformatf("vec%0d_data", i), ifa.fifo_data, vecs[i].exp_data);
        end

        // Five full cycles: beat from the first full cycle comes out of the skid on release.
        cyc_a(1, 0, 0, 0, '0);
        cyc_a(1, 0, 1, 0, tsv(20));
        chk("full5_pre_wr", ifa.fifo_wr, 1);
        cyc_a(1, 0, 1, 1, tsv(21));
        chk("full5_wr0", ifa.fifo_wr, 0);
        for (int i = 1; i < 5; i++) begin
            cyc_a(1, 0, 0, 1, '0);
            chk($sformatf("full5_wr%0d", i), ifa.fifo_wr, 0);
        end
        cyc_a(1, 0, 0, 0, '0);
        chk("full5_release_wr", ifa.fifo_wr, 1);
        chk("full5_release_data", ifa.fifo_data, tsv(21));
        cyc_a(0, 0, 0, 0, '0);

        // EIOS request with the skid occupied, EIOS_CNT=2, one full cycle in between.
        cyc_a(1, 0, 0, 0, '0);
        cyc_a(1, 0, 1, 1, tsv(30));
        cyc_a(1, 1, 0, 0, '0);
        chk("eios_enter_wr", ifa.fifo_wr, 0);
        cyc_a(1, 1, 0, 1, '0);
        chk("eios_hold_wr", ifa.fifo_wr, 0);
        cyc_a(1, 1, 0, 0, '0);
        chk("eios1_wr", ifa.fifo_wr, 1);
        chk("eios1_type", ifa.fifo_type, 2);
        chk("eios1_data", ifa.fifo_data, EIOS_BEAT);
        chk("eios1_done", ifa.eios_done, 0);
        cyc_a(1, 1, 0, 0, '0);
        chk("eios2_wr", ifa.fifo_wr, 1);
        chk("eios2_data", ifa.fifo_data, EIOS_BEAT);
        chk("eios2_done", ifa.eios_done, 1);
        cyc_a(1, 1, 0, 0, '0);
        chk("ei_no_skid_wr", ifa.fifo_wr, 0);
        chk("ei_done", ifa.eios_done, 1);
        cyc_a(0, 0, 0, 0, '0);
        chk("ei_exit_done", ifa.eios_done, 0);

        // Reset in the middle of EIOS after one beat.
        cyc_a(1, 0, 0, 0, '0);
        cyc_a(1, 1, 0, 0, '0);
        cyc_a(1, 1, 0, 0, '0);
        chk("rst_eios_beat", ifa.fifo_wr, 1);
        rst = 1;
        cyc_a(1, 1, 0, 0, '0);
        rst = 0;
        chk("rst_wr", ifa.fifo_wr, 0);
        chk("rst_data", ifa.fifo_data, 0);
        chk("rst_type", ifa.fifo_type, 0);
        chk("rst_done", ifa.eios_done, 0);
        chk("rst_stall", ifa.ts_stall, 1);
        cyc_a(0, 0, 0, 0, '0);
        chk("rst_idle_stall", stall_s, 1);
        cyc_a(1, 0, 0, 0, '0);
        chk("rst_txen_stall", stall_s, 1);
        cyc_a(1, 0, 0, 0, '0);
        chk("rst_run_stall", stall_s, 0);

        // tx_en falls in the cycle eios_req rises: IDLE wins.
        cyc_a(0, 1, 0, 0, '0);
        chk("race_wr", ifa.fifo_wr, 0);
        for (int i = 0; i < 3; i++) begin
            cyc_a(0, 1, 0, 0, '0);
            chk($sformatf("race_done%0d", i), ifa.eios_done, 0);
            chk($sformatf("race_stall%0d", i), stall_s, 1);
        end
        cyc_a(0, 0, 0, 0, '0);

        // SKP_INTERVAL=4 with the FIFO full for 10 cycles.
        cyc_b(1, 1);
        for (int i = 0; i < 10; i++) begin
            cyc_b(1, 1);
            chk($sformatf("ovr_wr%0d", i), ifb.fifo_wr, 0);
            if (i == 6) chk("ovr_before", ifb.skp_overrun, 0);
            if (i == 7) chk("ovr_after", ifb.skp_overrun, 1);
        end
        cyc_b(1, 0);
        chk("ovr_skp_wr", ifb.fifo_wr, 1);
        chk("ovr_skp_type", ifb.fifo_type, 1);
        chk("ovr_skp_data", ifb.fifo_data, SKP_BEAT);
        cyc_b(0, 0);
        chk("ovr_single_skp", ifb.fifo_wr, 0);
        cyc_b(0, 0);
        chk("ovr_sticky", ifb.skp_overrun, 1);
        rst = 1;
        cyc_b(0, 0);
        rst = 0;
        chk("ovr_rst_clear", ifb.skp_overrun, 0);

        // Randomized traffic on u_a against the model; first 200 cycles are a clean stream.
        rst = 1;
        cyc_a(0, 0, 0, 0, '0);
        rst = 0;
        m_reset();
        prev_stall = 1;
        last_skp = 0;
        for (int n = 0; n < 3000; n++) begin
            phase0 = (n < 200);
            r_rst = !phase0 && ($urandom_range(0, 499) == 0);
            if (phase0) tx = 1;
            else if (m_mode == M_DONE) tx = ($urandom_range(0, 3) == 0);
            else tx = ($urandom_range(0, 99) != 0);
            eq = !phase0 && ($urandom_range(0, 99) == 0);
            ff = !phase0 && ($urandom_range(0, 3) == 0);
            tv = !prev_stall && (phase0 || ($urandom_range(0, 9) < 7));
            d = {$urandom, $urandom, $urandom, $urandom};
            rst = r_rst;
            ifa.tx_en = tx; ifa.eios_req = eq; ifa.ts_valid = tv; ifa.fifo_full = ff; ifa.ts = d;
            @(negedge clk);
            exp_stall = ff | m_pending | (m_skid.size() != 0) | (m_mode != M_ON);
            chk("rnd_stall", ifa.ts_stall, exp_stall);
            if (phase0) chk("rnd_skid_after_skp", u_a.skid_valid, last_skp);
            prev_stall = ifa.ts_stall;
            @(posedge clk);
            if (r_rst) m_reset();
            else m_step(tx, eq, tv, ff, d);
            #1;
            rst = 0;
            if (r_rst) prev_stall = 1;
            last_skp = m_wr && (m_type == 2'd1);
            chk("rnd_wr", ifa.fifo_wr, m_wr);
            chk("rnd_data", ifa.fifo_data, m_data);
            chk("rnd_type", ifa.fifo_type, m_type);
            chk("rnd_eios_done", ifa.eios_done, m_mode == M_DONE);
            chk("rnd_overrun", ifa.skp_overrun, m_over);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
